// File: rtl/nios_setup_led_pkg.sv
// Shared constants for the Nios LED/output port controller: register map and mode encoding.
package nios_setup_led_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_SET      = 3'd1;
  localparam logic [2:0] ADDR_CLR      = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE   = 3'd3;
  localparam logic [2:0] ADDR_MODE     = 3'd4;
  localparam logic [2:0] ADDR_PRESCALE = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_BLINK  = 1'b1;

endpackage

// File: rtl/nios_setup_led_ctrl_if.sv
// Avalon-MM slave bus bundle for the LED controller (zero wait states, read latency 0).
interface nios_setup_led_ctrl_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/nios_setup_led_tick.sv
// Blink timebase: reloadable down-counter that toggles phase each time it expires.
module nios_setup_led_tick #(
  parameter int               PRE_W     = 24,
  parameter logic [PRE_W-1:0] PRE_RESET = PRE_W'(2499999)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [PRE_W-1:0] load_val,
  output logic             phase,
  output logic             tick
);

  logic [PRE_W-1:0] r_cnt;
  logic             r_phase;

  assign tick  = (r_cnt == '0);
  assign phase = r_phase;

  // A load beats an expiring count: the counter restarts and phase is forced high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= PRE_RESET;
      r_phase <= 1'b1;
    end else if (load) begin
      r_cnt   <= load_val;
      r_phase <= 1'b1;
    end else if (tick) begin
      r_cnt   <= load_val;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/nios_setup_led_ctrl.sv
// Avalon-MM output port with atomic set/clear/toggle and per-bit hardware blink.
module nios_setup_led_ctrl
  import nios_setup_led_pkg::*;
#(
  parameter int               WIDTH      = 3,
  parameter int               PRE_W      = 24,
  parameter logic [WIDTH-1:0] DATA_RESET = '0,
  parameter logic [PRE_W-1:0] PRE_RESET  = PRE_W'(2499999)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nios_setup_led_ctrl_if.slave   bus,
  output logic [WIDTH-1:0]       out_port
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mode;
  logic [PRE_W-1:0] r_prescale;

  logic             w_wr;
  logic             w_pre_wr;
  logic [WIDTH-1:0] w_wd;
  logic [PRE_W-1:0] w_load_val;
  logic             w_phase;
  logic             w_tick;
  logic [31:0]      w_readdata;
  logic             w_unused;

  assign w_wr     = bus.chipselect && !bus.write_n;
  assign w_pre_wr = w_wr && (bus.address == ADDR_PRESCALE);
  assign w_wd     = bus.writedata[WIDTH-1:0];
  // The tick block reloads from this value both on a bus write and on expiry.
  assign w_load_val = w_pre_wr ? bus.writedata[PRE_W-1:0] : r_prescale;
  assign w_unused   = &{1'b0, bus.writedata, w_tick};

  nios_setup_led_tick #(
    .PRE_W     (PRE_W),
    .PRE_RESET (PRE_RESET)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_pre_wr),
    .load_val (w_load_val),
    .phase    (w_phase),
    .tick     (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= DATA_RESET;
      r_mode     <= '0;
      r_prescale <= PRE_RESET;
    end else if (w_wr) begin
      case (bus.address)
        ADDR_DATA:     r_data     <= w_wd;
        ADDR_SET:      r_data     <= r_data | w_wd;
        ADDR_CLR:      r_data     <= r_data & ~w_wd;
        ADDR_TOGGLE:   r_data     <= r_data ^ w_wd;
        ADDR_MODE:     r_mode     <= w_wd;
        ADDR_PRESCALE: r_prescale <= bus.writedata[PRE_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_readdata = '0;
    case (bus.address)
      ADDR_DATA:     w_readdata[WIDTH-1:0] = r_data;
      ADDR_MODE:     w_readdata[WIDTH-1:0] = r_mode;
      ADDR_PRESCALE: w_readdata[PRE_W-1:0] = r_prescale;
      ADDR_STATUS:   w_readdata[0]         = w_phase;
      default: ;
    endcase
  end

  assign bus.readdata = w_readdata;

  // Blinking bits follow phase; static bits pass data straight through.
  assign out_port = r_data & (~r_mode | {WIDTH{w_phase}});

endmodule

// File: tb/tb_nios_setup_led_ctrl.sv
// Directed bench for nios_setup_led_ctrl: register table, blink timing, load/tick collision, async reset, 32-bit build.
module tb_nios_setup_led_ctrl;
  import nios_setup_led_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios_setup_led_ctrl_if bus3 ();
  nios_setup_led_ctrl_if bus32 ();
  logic [2:0]  out3;
  logic [31:0] out32;

  nios_setup_led_ctrl #(.WIDTH(3), .DATA_RESET(3'b101)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3.slave), .out_port(out3));

  nios_setup_led_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(bus32.slave), .out_port(out32));

  typedef struct {
    logic        cs;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
    logic [2:0]  exp_out;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input bit w32, input logic cs, input logic wr, input logic [2:0] a,
                       input logic [31:0] d);
    if (w32) begin
      bus32.chipselect = cs; bus32.write_n = ~wr; bus32.address = a; bus32.writedata = d;
    end else begin
      bus3.chipselect = cs; bus3.write_n = ~wr; bus3.address = a; bus3.writedata = d;
    end
  endtask

  // Write lands on the next posedge; returns 1 time unit after it with the bus idle.
  task automatic bwr(input bit w32, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(w32, 1'b1, 1'b1, a, d);
    @(posedge clk);
    #1;
    drive(w32, 1'b0, 1'b0, a, 32'h0);
  endtask

  vec_t vecs[12];
  logic exp_ph;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, ADDR_DATA,     32'd7,         ADDR_DATA,   32'd0, 3'b111};
    vecs[1]  = '{1'b1, 1'b1, ADDR_CLR,      32'd2,         ADDR_CLR,    32'd0, 3'b101};
    vecs[2]  = '{1'b1, 1'b1, ADDR_SET,      32'd8,         ADDR_SET,    32'd0, 3'b101};
    vecs[3]  = '{1'b1, 1'b1, ADDR_TOGGLE,   32'd1,         ADDR_TOGGLE, 32'd0, 3'b100};
    vecs[4]  = '{1'b0, 1'b0, ADDR_DATA,     32'd0,         ADDR_DATA,   32'd4, 3'b100};
    vecs[5]  = '{1'b1, 1'b1, 3'd7,          32'hFF,        3'd7,        32'd0, 3'b100};
    vecs[6]  = '{1'b0, 1'b1, ADDR_DATA,     32'd3,         ADDR_DATA,   32'd4, 3'b100};
    vecs[7]  = '{1'b1, 1'b0, ADDR_DATA,     32'd3,         ADDR_DATA,   32'd4, 3'b100};
    vecs[8]  = '{1'b1, 1'b1, ADDR_SET,      32'd3,         ADDR_DATA,   32'd7, 3'b111};
    vecs[9]  = '{1'b1, 1'b1, ADDR_MODE,     32'd0,         ADDR_MODE,   32'd0, 3'b111};
    vecs[10] = '{1'b1, 1'b1, ADDR_TOGGLE,   32'hFFFF_FFFA, ADDR_DATA,   32'd5, 3'b101};
    vecs[11] = '{1'b1, 1'b1, ADDR_CLR,      32'd5,         ADDR_DATA,   32'd0, 3'b000};
    vecs[0].exp_rd = 32'd7;

    drive(1'b0, 1'b0, 1'b0, ADDR_DATA, 32'h0);
    drive(1'b1, 1'b0, 1'b0, ADDR_DATA, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out3", {29'b0, out3}, 32'h5);
    chk("rst_out32", out32, 32'h0);
    chk("rst_data3", bus3.readdata, 32'h5);
    bus3.address = ADDR_PRESCALE; bus32.address = ADDR_PRESCALE;
    #1;
    chk("rst_pre3", bus3.readdata, 32'd2499999);
    chk("rst_pre32", bus32.readdata, 32'd2499999);
    bus3.address = ADDR_STATUS;
    #1;
    chk("rst_status3", bus3.readdata, 32'd1);
    bus3.address = ADDR_MODE;
    #1;
    chk("rst_mode3", bus3.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Register table on the 3-bit build
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b0, vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, vecs[i].raddr, 32'h0);
      #1;
      chk($sformatf("vec%0d_rd", i), bus3.readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_out", i), {29'b0, out3}, {29'b0, vecs[i].exp_out});
    end

    // Blink: bit1 blinks with PRESCALE=3, bit0 static
    bwr(1'b0, ADDR_DATA, 32'd3);
    bwr(1'b0, ADDR_MODE, 32'd2);
    bus3.address = ADDR_MODE;
    #1;
    chk("mode_rd", bus3.readdata, 32'd2);
    bwr(1'b0, ADDR_PRESCALE, 32'd3);
    bus3.address = ADDR_STATUS;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #2;
      end
      exp_ph = ((k / 4) % 2) == 0;
      chk($sformatf("blink3_out_k%0d", k), {29'b0, out3}, {29'b0, 1'b0, exp_ph, 1'b1});
      chk($sformatf("blink3_st_k%0d", k), bus3.readdata, {31'b0, exp_ph});
    end

    // Counter is 0 here with phase high: PRESCALE write must win without a toggle
    bwr(1'b0, ADDR_PRESCALE, 32'd5);
    bus3.address = ADDR_STATUS;
    #1;
    for (int j = 0; j < 14; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #2;
      end
      exp_ph = ((j / 6) % 2) == 0;
      chk($sformatf("blink5_out_j%0d", j), {29'b0, out3}, {29'b0, 1'b0, exp_ph, 1'b1});
      chk($sformatf("blink5_st_j%0d", j), bus3.readdata, {31'b0, exp_ph});
    end
    bus3.address = ADDR_PRESCALE;
    #1;
    chk("pre5_rd", bus3.readdata, 32'd5);

    // Asynchronous reset in the middle of blinking
    bwr(1'b0, ADDR_DATA, 32'd7);
    bwr(1'b1, ADDR_DATA, 32'h1234_5678);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    bus3.address = ADDR_STATUS;
    #1;
    chk("arst_out3", {29'b0, out3}, 32'h5);
    chk("arst_status", bus3.readdata, 32'd1);
    chk("arst_out32", out32, 32'h0);
    bus3.address = ADDR_PRESCALE;
    #1;
    chk("arst_pre3", bus3.readdata, 32'd2499999);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 32-bit build, full-width toggle
    bwr(1'b1, ADDR_DATA, 32'hFFFF_FFFF);
    bus32.address = ADDR_DATA;
    #1;
    chk("w32_data", bus32.readdata, 32'hFFFF_FFFF);
    bwr(1'b1, ADDR_TOGGLE, 32'h8000_0001);
    bus32.address = ADDR_DATA;
    #1;
    chk("w32_toggle_rd", bus32.readdata, 32'h7FFF_FFFE);
    chk("w32_toggle_out", out32, 32'h7FFF_FFFE);
    bwr(1'b1, ADDR_CLR, 32'h0F0F_0000);
    bus32.address = ADDR_DATA;
    #1;
    chk("w32_clr_rd", bus32.readdata, 32'h70F0_FFFE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
